lcd_frame_scheduler: RTL and testbench

Frame sequencer sitting between the VPU pixel stream and the ILI9341 8-bit parallel byte writer. Once the panel reports init done, it opens a full-screen window with CASET, PASET and RAMWR, then streams H_RES×V_RES pixels as RGB565 byte pairs. Between frames it inserts a programmable vblank gap. It tracks pixel coordinates and a frame counter, so the VPU and the top level stay frame-aligned.

---
 rtl/lcd_frame_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_lcd_frame_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_scheduler.sv
// Frame sequencer: opens a full-screen ILI9341 window (CASET/PASET/RAMWR) and then
// streams RGB565 byte pairs from the VPU. A vblank gap follows each frame.
module lcd_frame_scheduler #(
  parameter int H_RES         = 320,
  parameter int V_RES         = 240,
  parameter int VBLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       initialized,
  input  logic       frame_en,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic       bus_dc,
  output logic [7:0] bus_data,
  output logic [8:0] pix_x,
  output logic [7:0] pix_y,
  output logic [7:0] frame_cnt,
  output logic       vblank,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CASET, S_CARG, S_PASET, S_PARG, S_RAMWR, S_PIXEL, S_VBLANK
  } state_t;

  localparam logic [8:0]  X_LAST  = 9'(H_RES - 1);
  localparam logic [7:0]  Y_LAST  = 8'(V_RES - 1);
  localparam logic [15:0] H_END   = 16'(H_RES - 1);
  localparam logic [15:0] V_END   = 16'(V_RES - 1);
  localparam logic [15:0] VB_LOAD = 16'(VBLANK_CYCLES);

  state_t      state, state_d;
  logic [1:0]  arg_idx, arg_idx_d;
  logic        phase_lo, phase_lo_d;
  logic        last_pix, last_pix_d;
  logic [15:0] vb_cnt, vb_cnt_d;
  logic [8:0]  pix_x_d;
  logic [7:0]  pix_y_d;
  logic [7:0]  frame_cnt_d;
  logic        load, load_dc, latch_lo;
  logic [7:0]  load_data;
  logic [7:0]  lo_byte;
  logic        slot_free, taken, accept;
  logic        unused_bits;

  // Window argument bytes: two zero start bytes, then the 16-bit end coordinate MSB first.
  function automatic logic [7:0] arg_byte(input logic [1:0] idx, input logic [15:0] end_v);
    case (idx)
      2'd2:    arg_byte = end_v[15:8];
      2'd3:    arg_byte = end_v[7:0];
      default: arg_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rgb_hi(input logic [7:0] r, input logic [7:0] g);
    rgb_hi = {r[7:3], g[7:5]};
  endfunction

  function automatic logic [7:0] rgb_lo(input logic [7:0] g, input logic [7:0] b);
    rgb_lo = {g[4:2], b[7:3]};
  endfunction

  assign unused_bits = ^{pix_r[2:0], pix_g[1:0], pix_b[2:0]};

  assign slot_free = !bus_valid || bus_ready;
  assign taken     = bus_valid && bus_ready;
  assign pix_ready = (state == S_PIXEL) && !phase_lo && !last_pix && slot_free;
  assign accept    = pix_ready && pix_valid;
  assign vblank    = (state == S_VBLANK);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_d     = state;
    arg_idx_d   = arg_idx;
    phase_lo_d  = phase_lo;
    last_pix_d  = last_pix;
    vb_cnt_d    = vb_cnt;
    pix_x_d     = pix_x;
    pix_y_d     = pix_y;
    frame_cnt_d = frame_cnt;
    load        = 1'b0;
    load_dc     = 1'b1;
    load_data   = 8'h00;
    latch_lo    = 1'b0;
    case (state)
      S_IDLE: begin
        if (initialized && frame_en) state_d = S_CASET;
      end
      S_CASET: begin
        if (slot_free) begin
          load      = 1'b1;
          load_dc   = 1'b0;
          load_data = 8'h2A;
          arg_idx_d = 2'd0;
          state_d   = S_CARG;
        end
      end
      S_CARG: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = arg_byte(arg_idx, H_END);
          arg_idx_d = arg_idx + 2'd1;
          if (arg_idx == 2'd3) state_d = S_PASET;
        end
      end
      S_PASET: begin
        if (slot_free) begin
          load      = 1'b1;
          load_dc   = 1'b0;
          load_data = 8'h2B;
          arg_idx_d = 2'd0;
          state_d   = S_PARG;
        end
      end
      S_PARG: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = arg_byte(arg_idx, V_END);
          arg_idx_d = arg_idx + 2'd1;
          if (arg_idx == 2'd3) state_d = S_RAMWR;
        end
      end
      S_RAMWR: begin
        if (slot_free) begin
          load       = 1'b1;
          load_dc    = 1'b0;
          load_data  = 8'h2C;
          pix_x_d    = 9'd0;
          pix_y_d    = 8'd0;
          phase_lo_d = 1'b0;
          last_pix_d = 1'b0;
          state_d    = S_PIXEL;
        end
      end
      S_PIXEL: begin
        if (phase_lo) begin
          if (slot_free) begin
            load       = 1'b1;
            load_data  = lo_byte;
            phase_lo_d = 1'b0;
          end
        end else if (last_pix) begin
          // Frame ends only once the final lo byte has actually left the register.
          if (taken) begin
            last_pix_d  = 1'b0;
            frame_cnt_d = frame_cnt + 8'd1;
            vb_cnt_d    = VB_LOAD;
            state_d     = S_VBLANK;
          end
        end else if (accept) begin
          load       = 1'b1;
          load_data  = rgb_hi(pix_r, pix_g);
          latch_lo   = 1'b1;
          phase_lo_d = 1'b1;
          if (pix_x == X_LAST) begin
            pix_x_d = 9'd0;
            if (pix_y == Y_LAST) begin
              pix_y_d    = 8'd0;
              last_pix_d = 1'b1;
            end else begin
              pix_y_d = pix_y + 8'd1;
            end
          end else begin
            pix_x_d = pix_x + 9'd1;
          end
        end
      end
      S_VBLANK: begin
        if (vb_cnt <= 16'd1) state_d = S_IDLE;
        else                 vb_cnt_d = vb_cnt - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      arg_idx   <= 2'd0;
      phase_lo  <= 1'b0;
      last_pix  <= 1'b0;
      vb_cnt    <= 16'd0;
      pix_x     <= 9'd0;
      pix_y     <= 8'd0;
      frame_cnt <= 8'd0;
      bus_valid <= 1'b0;
      bus_dc    <= 1'b0;
      bus_data  <= 8'h00;
    end else begin
      state     <= state_d;
      arg_idx   <= arg_idx_d;
      phase_lo  <= phase_lo_d;
      last_pix  <= last_pix_d;
      vb_cnt    <= vb_cnt_d;
      pix_x     <= pix_x_d;
      pix_y     <= pix_y_d;
      frame_cnt <= frame_cnt_d;
      if (load) begin
        bus_valid <= 1'b1;
        bus_dc    <= load_dc;
        bus_data  <= load_data;
      end else if (bus_ready) begin
        bus_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_lo) lo_byte <= rgb_lo(pix_g, pix_b);
  end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed bench: default-size DUT for header/pixel bytes and mid-frame reset,
// a 5x3 DUT under random backpressure, and a 4x2 DUT for frame counter wrap.
module tb_lcd_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       a_init, a_fen, a_pv, a_pr, a_bv, a_br, a_dc, a_vb, a_busy;
  logic [7:0] a_r, a_g, a_b, a_data, a_y, a_fc;
  logic [8:0] a_x;
  logic       b_init, b_fen, b_pv, b_pr, b_bv, b_br, b_dc, b_vb, b_busy;
  logic [7:0] b_r, b_g, b_b, b_data, b_y, b_fc;
  logic [8:0] b_x;
  logic       c_init, c_fen, c_pv, c_pr, c_bv, c_br, c_dc, c_vb, c_busy;
  logic [7:0] c_r, c_g, c_b, c_data, c_y, c_fc;
  logic [8:0] c_x;

  lcd_frame_scheduler dut_a (
    .clk(clk), .reset(reset), .initialized(a_init), .frame_en(a_fen),
    .pix_valid(a_pv), .pix_ready(a_pr), .pix_r(a_r), .pix_g(a_g), .pix_b(a_b),
    .bus_valid(a_bv), .bus_ready(a_br), .bus_dc(a_dc), .bus_data(a_data),
    .pix_x(a_x), .pix_y(a_y), .frame_cnt(a_fc), .vblank(a_vb), .busy(a_busy)
  );

  lcd_frame_scheduler #(.H_RES(5), .V_RES(3), .VBLANK_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .initialized(b_init), .frame_en(b_fen),
    .pix_valid(b_pv), .pix_ready(b_pr), .pix_r(b_r), .pix_g(b_g), .pix_b(b_b),
    .bus_valid(b_bv), .bus_ready(b_br), .bus_dc(b_dc), .bus_data(b_data),
    .pix_x(b_x), .pix_y(b_y), .frame_cnt(b_fc), .vblank(b_vb), .busy(b_busy)
  );

  lcd_frame_scheduler #(.H_RES(4), .V_RES(2), .VBLANK_CYCLES(1)) dut_c (
    .clk(clk), .reset(reset), .initialized(c_init), .frame_en(c_fen),
    .pix_valid(c_pv), .pix_ready(c_pr), .pix_r(c_r), .pix_g(c_g), .pix_b(c_b),
    .bus_valid(c_bv), .bus_ready(c_br), .bus_dc(c_dc), .bus_data(c_data),
    .pix_x(c_x), .pix_y(c_y), .frame_cnt(c_fc), .vblank(c_vb), .busy(c_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Row 0: 320x240 window; row 1: 5x3 window.
  logic [7:0] hdr [2][11] = '{
    '{8'h2A, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h2B, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h2C},
    '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h04, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h02, 8'h2C}
  };
  logic       hdr_dc [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // Even pixels: magenta; odd pixels: pure green.
  logic [7:0] pat_r  [2] = '{8'hFF, 8'h00};
  logic [7:0] pat_g  [2] = '{8'h00, 8'hFC};
  logic [7:0] pat_b  [2] = '{8'hFF, 8'h00};
  logic [7:0] pat_hi [2] = '{8'hF8, 8'h07};
  logic [7:0] pat_lo [2] = '{8'h1F, 8'hE0};

  function automatic logic [7:0] exp_data(input int which, input int n);
    if (n < 11) return hdr[which][n];
    if (((n - 11) % 2) == 0) return pat_hi[((n - 11) / 2) % 2];
    return pat_lo[((n - 11) / 2) % 2];
  endfunction

  function automatic logic exp_dc(input int n);
    if (n < 11) return hdr_dc[n];
    return 1'b1;
  endfunction

  int  cyc, nbytes, npix, last_acc, hold_err, vbc, frames;
  bit  prev_stall, got_first;
  logic [7:0] prev_data;
  logic       prev_dc;

  initial begin
    reset = 1'b1;
    {a_init, a_fen, a_pv, a_br, a_r, a_g, a_b} = '0;
    {b_init, b_fen, b_pv, b_br, b_r, b_g, b_b} = '0;
    {c_init, c_fen, c_pv, c_br, c_r, c_g, c_b} = '0;

    @(negedge clk); #1;
    check("rst_bus_valid", 32'(a_bv), 0);
    check("rst_bus_dc", 32'(a_dc), 0);
    check("rst_bus_data", 32'(a_data), 0);
    check("rst_pix_ready", 32'(a_pr), 0);
    check("rst_pix_x", 32'(a_x), 0);
    check("rst_pix_y", 32'(a_y), 0);
    check("rst_frame_cnt", 32'(a_fc), 0);
    check("rst_vblank", 32'(a_vb), 0);
    check("rst_busy", 32'(a_busy), 0);

    // Default-size DUT: header, pixel bytes and coordinates over 1000 pixels.
    @(negedge clk);
    reset = 1'b0;
    a_init = 1'b1; a_fen = 1'b1; a_br = 1'b1; a_pv = 1'b1;
    cyc = 0; nbytes = 0; npix = 0; last_acc = -1;
    while (npix < 1000 && cyc < 2600) begin
      a_r = pat_r[npix % 2]; a_g = pat_g[npix % 2]; a_b = pat_b[npix % 2];
      #1;
      if (cyc == 1) begin
        check("a_lat_idle_valid", 32'(a_bv), 0);
        check("a_lat_busy", 32'(a_busy), 1);
      end
      if (cyc == 2) check("a_lat_first_valid", 32'(a_bv), 1);
      if (a_bv && a_br) begin
        check("a_byte_data", 32'(a_data), 32'(exp_data(0, nbytes)));
        check("a_byte_dc", 32'(a_dc), 32'(exp_dc(nbytes)));
        nbytes++;
      end
      if (a_pv && a_pr) begin
        check("a_pix_x", 32'(a_x), npix % 320);
        check("a_pix_y", 32'(a_y), npix / 320);
        npix++;
        last_acc = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    check("a_pixels", npix, 1000);
    check("a_rate_last_accept_cycle", last_acc, 12 + 2 * 999);
    #1;
    check("a_pix_x_before_reset", 32'(a_x), 40);
    check("a_pix_y_before_reset", 32'(a_y), 3);
    reset = 1'b1;
    #1;
    check("a_midrst_bus_valid", 32'(a_bv), 0);
    check("a_midrst_pix_ready", 32'(a_pr), 0);
    check("a_midrst_pix_x", 32'(a_x), 0);
    check("a_midrst_pix_y", 32'(a_y), 0);
    check("a_midrst_frame_cnt", 32'(a_fc), 0);
    @(negedge clk);
    reset = 1'b0;
    got_first = 1'b0;
    for (int i = 0; i < 20 && !got_first; i++) begin
      #1;
      if (a_bv && a_br) begin
        got_first = 1'b1;
        check("a_restart_data", 32'(a_data), 32'h2A);
        check("a_restart_dc", 32'(a_dc), 0);
      end
      @(negedge clk);
    end
    check("a_restart_seen", 32'(got_first), 1);
    a_fen = 1'b0; a_pv = 1'b0;

    // 5x3 DUT under random backpressure and pixel gaps; frame_en dropped mid-frame.
    b_init = 1'b1; b_fen = 1'b1;
    cyc = 0; nbytes = 0; npix = 0; hold_err = 0; prev_stall = 1'b0;
    prev_data = '0; prev_dc = 1'b0;
    while (cyc < 3000) begin
      b_br = 1'($urandom_range(0, 1));
      b_pv = ($urandom_range(0, 3) != 0);
      b_r = pat_r[npix % 2]; b_g = pat_g[npix % 2]; b_b = pat_b[npix % 2];
      if (nbytes >= 5) b_fen = 1'b0;
      #1;
      if (b_vb) break;
      if (prev_stall && (!b_bv || b_data != prev_data || b_dc != prev_dc)) hold_err++;
      if (b_bv && !b_br && b_pr) hold_err++;
      prev_stall = b_bv && !b_br;
      prev_data  = b_data;
      prev_dc    = b_dc;
      if (b_bv && b_br) begin
        check("b_byte_data", 32'(b_data), 32'(exp_data(1, nbytes)));
        check("b_byte_dc", 32'(b_dc), 32'(exp_dc(nbytes)));
        nbytes++;
      end
      if (b_pv && b_pr) begin
        check("b_pix_x", 32'(b_x), npix % 5);
        check("b_pix_y", 32'(b_y), npix / 5);
        npix++;
      end
      cyc++;
      @(negedge clk);
    end
    check("b_vblank_reached", 32'(b_vb), 1);
    check("b_frame_bytes", nbytes, 41);
    check("b_frame_pixels", npix, 15);
    check("b_hold_violations", hold_err, 0);
    check("b_wrap_pix_x", 32'(b_x), 0);
    check("b_wrap_pix_y", 32'(b_y), 0);
    check("b_frame_cnt", 32'(b_fc), 1);
    b_br = 1'b1;
    vbc = 0;
    while (b_vb && vbc < 100) begin
      vbc++;
      @(negedge clk); #1;
    end
    check("b_vblank_len", vbc, 16);
    repeat (5) @(negedge clk);
    #1;
    check("b_idle_busy", 32'(b_busy), 0);
    check("b_idle_bus_valid", 32'(b_bv), 0);
    check("b_idle_frame_cnt", 32'(b_fc), 1);

    // 4x2 DUT, vblank of one cycle: 256 back-to-back frames wrap the counter.
    c_init = 1'b1; c_fen = 1'b1; c_br = 1'b1; c_pv = 1'b1;
    cyc = 0; nbytes = 0; frames = 0;
    while (frames < 256 && cyc < 12000) begin
      #1;
      if (c_bv && c_br) nbytes++;
      if (c_vb) begin
        frames++;
        check("c_frame_bytes", nbytes, 27);
        check("c_frame_cnt", 32'(c_fc), 32'(frames % 256));
        nbytes = 0;
        if (frames == 256) c_fen = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    check("c_frames_done", frames, 256);
    check("c_frame_cnt_wrapped", 32'(c_fc), 0);
    repeat (4) @(negedge clk);
    #1;
    check("c_idle_busy", 32'(c_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
